wall_row_renderer: RTL and testbench

- Downstream of the wall tracer. Consumes the per-line wall half-size and side that the tracer presents on hmax.
- Turns them into per-pixel region classification (sky / wall / floor) and a 6-bit texture coordinate along the wall's height, for the pixel/colour stage.
- The screen is rotated, so each scanline is one wall slice centred on HALF_W.
- Between lines, an iterative divider and shift-add multiplier prepare the texel step and the clipped start offset. The visible area then uses only an accumulator.

---
 rtl/wall_row_renderer.sv | 164 ++++++++++++++++
 tb/tb_wall_row_renderer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wall_row_renderer.sv
// Per-scanline wall renderer: classifies each pixel as sky/wall/floor and
// generates the 6-bit texel row along the wall. Between lines an iterative
// divider and shift-add multiplier prepare the texel step and clipped preload.
module wall_row_renderer #(
  parameter int unsigned H_VIEW = 640,
  parameter int unsigned HALF_W = 320,
  parameter int unsigned FRAC   = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hmax,
  input  logic [10:0] i_size,
  input  logic        i_side,
  input  logic [9:0]  hpos,
  output logic [1:0]  o_region,
  output logic [5:0]  o_tex_v,
  output logic        o_side,
  output logic        o_ready
);

  typedef enum logic [1:0] {StIdle, StDiv, StMul, StReady} state_e;

  localparam logic [10:0] HalfW11 = 11'(HALF_W);
  localparam logic [11:0] HalfW12 = 12'(HALF_W);
  localparam logic [11:0] HView12 = 12'(H_VIEW);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] size_q, size_d;
  logic        side_q, side_d;
  logic [15:0] step_q, step_d;
  logic [15:0] acc_q, acc_d;
  // num: dividend shifter in DIV, multiplicand shifter in MUL
  logic [15:0] num_q, num_d;
  // rem: partial remainder in DIV, multiplier bits of k in MUL
  logic [11:0] rem_q, rem_d;
  logic        ready_q, ready_d;
  logic        vld_q, vld_d;
  logic        hmax_q;
  logic [1:0]  region_q, region_d;
  logic [5:0]  tex_q, tex_d;

  logic [11:0] rem_sh, rem_sub;
  logic        rem_ge;
  logic [15:0] quo_next, step_fin;
  logic [10:0] k;
  logic [11:0] hpos_ext, hpos_plus, wall_end;
  logic        pix_sky, pix_wall;

  // Divider datapath, clip offset and span decode
  always_comb begin
    rem_sh    = {rem_q[10:0], num_q[15]};
    rem_ge    = rem_sh >= {1'b0, size_q};
    rem_sub   = rem_sh - {1'b0, size_q};
    quo_next  = {step_q[14:0], rem_ge};
    step_fin  = (size_q == 11'd0) ? 16'd0 : quo_next;
    k         = (size_q > HalfW11) ? size_q - HalfW11 : 11'd0;
    // Compare hpos + size against HALF_W to stay unsigned with no overflow
    hpos_ext  = {2'b00, hpos};
    hpos_plus = hpos_ext + {1'b0, size_q};
    wall_end  = HalfW12 + {1'b0, size_q};
    pix_sky   = hpos_plus < HalfW12;
    pix_wall  = !pix_sky && (hpos_ext < wall_end) && (hpos_ext < HView12);
  end

  // Next-state: capture/abort, DIV and MUL sequencing, pixel pipeline
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    size_d   = size_q;
    side_d   = side_q;
    step_d   = step_q;
    acc_d    = acc_q;
    num_d    = num_q;
    rem_d    = rem_q;
    ready_d  = ready_q;
    vld_d    = vld_q;
    region_d = 2'd0;
    tex_d    = 6'd0;

    if (hmax_q) begin
      // A new line always restarts from scratch, whatever the current state
      size_d  = i_size;
      side_d  = i_side;
      ready_d = 1'b0;
      vld_d   = 1'b1;
      acc_d   = 16'd0;
      step_d  = 16'd0;
      num_d   = 16'h8000;
      rem_d   = 12'd0;
      cnt_d   = 4'd0;
      state_d = StDiv;
    end else begin
      unique case (state_q)
        StIdle: ;
        StDiv: begin
          rem_d  = rem_ge ? rem_sub : rem_sh;
          num_d  = {num_q[14:0], 1'b0};
          step_d = quo_next;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            step_d  = step_fin;
            num_d   = step_fin;
            rem_d   = {1'b0, k};
            cnt_d   = 4'd0;
            state_d = StMul;
          end
        end
        StMul: begin
          if (rem_q[0]) acc_d = acc_q + num_q;
          num_d = {num_q[14:0], 1'b0};
          rem_d = {1'b0, rem_q[11:1]};
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd10) state_d = StReady;
        end
        StReady: ready_d = 1'b1;
        default: state_d = StIdle;
      endcase
      if (ready_q && pix_wall) acc_d = acc_q + step_q;
    end

    if (vld_q) region_d = pix_sky ? 2'd0 : (pix_wall ? 2'd1 : 2'd2);
    if (ready_q && pix_wall) tex_d = acc_q[FRAC +: 6];
  end

  // State and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      size_q   <= 11'd0;
      side_q   <= 1'b0;
      step_q   <= 16'd0;
      acc_q    <= 16'd0;
      num_q    <= 16'd0;
      rem_q    <= 12'd0;
      ready_q  <= 1'b0;
      vld_q    <= 1'b0;
      hmax_q   <= 1'b0;
      region_q <= 2'd0;
      tex_q    <= 6'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      size_q   <= size_d;
      side_q   <= side_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      num_q    <= num_d;
      rem_q    <= rem_d;
      ready_q  <= ready_d;
      vld_q    <= vld_d;
      hmax_q   <= hmax;
      region_q <= region_d;
      tex_q    <= tex_d;
    end
  end

  assign o_region = region_q;
  assign o_tex_v  = tex_q;
  assign o_side   = side_q;
  assign o_ready  = ready_q;

endmodule

// File: tb/tb_wall_row_renderer.sv
// Bench for wall_row_renderer: directed lines from the test plan plus random
// lines and random aborts, checked against an arithmetic reference model.
module tb_wall_row_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hmax;
  logic [10:0] i_size;
  logic        i_side;
  logic [9:0]  hpos;
  logic [1:0]  o_region;
  logic [5:0]  o_tex_v;
  logic        o_side;
  logic        o_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wall_row_renderer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .hmax     (hmax),
    .i_size   (i_size),
    .i_side   (i_side),
    .hpos     (hpos),
    .o_region (o_region),
    .o_tex_v  (o_tex_v),
    .o_side   (o_side),
    .o_ready  (o_ready)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: texel step, span classification and texel row
  function automatic int model_step(input int s);
    return (s == 0) ? 0 : 32768 / s;
  endfunction

  function automatic int model_region(input int s, input int x);
    if (x < 320 - s) return 0;
    if (x < 320 + s) return 1;
    return 2;
  endfunction

  function automatic int model_tex(input int s, input int x);
    if (model_region(s, x) != 1) return 0;
    return (((x - (320 - s)) * model_step(s)) % 65536) / 1024;
  endfunction

  // Pulse hmax with the new line data; returns 1 ns after the capture edge
  task automatic capture_line(input int s, input int side);
    hmax   = 1'b1;
    i_size = 11'(s);
    i_side = 1'(side);
    @(posedge clk); #1;
    hmax = 1'b0;
    @(posedge clk); #1;
    check_eq("ready_clr_at_capture", int'(o_ready), 0);
    check_eq("side_at_capture", int'(o_side), side);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk); #1;
      if (o_ready) begin
        n = i;
        break;
      end
    end
    check_eq(tag, n, 28);
  endtask

  task automatic sweep(input int s, input int side, input int last_x);
    for (int x = 0; x <= last_x; x++) begin
      hpos = 10'(x);
      @(posedge clk); #1;
      check_eq($sformatf("region s=%0d x=%0d", s, x), int'(o_region), model_region(s, x));
      check_eq($sformatf("tex s=%0d x=%0d", s, x), int'(o_tex_v), model_tex(s, x));
    end
    check_eq("side_held", int'(o_side), side);
    check_eq("ready_held", int'(o_ready), 1);
  endtask

  task automatic full_line(input int s, input int side);
    capture_line(s, side);
    wait_ready($sformatf("latency s=%0d", s));
    sweep(s, side, 639);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_region"}, int'(o_region), 0);
    check_eq({tag, "_tex"}, int'(o_tex_v), 0);
    check_eq({tag, "_side"}, int'(o_side), 0);
    check_eq({tag, "_ready"}, int'(o_ready), 0);
  endtask

  initial begin
    int s;
    int side;
    int dly;
    reset_n = 1'b0;
    hmax    = 1'b0;
    i_size  = 11'd0;
    i_side  = 1'b0;
    hpos    = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    #2 reset_n = 1'b1;
    hpos = 10'd500;
    @(posedge clk); #1;
    check_all_zero("post_reset_idle");

    // One texel per pixel, then zero size, clipped and minimum sizes
    full_line(32, 1);
    full_line(0, 0);
    full_line(400, 1);
    full_line(2047, 0);
    full_line(1, 1);

    // Abort mid-DIV: latency counts from the second capture
    capture_line(32, 0);
    repeat (8) @(posedge clk);
    #1;
    capture_line(64, 1);
    wait_ready("latency_abort_div");
    sweep(64, 1, 639);

    // Async reset in the middle of wall pixels
    capture_line(32, 1);
    wait_ready("latency_pre_reset");
    sweep(32, 1, 300);
    #3 reset_n = 1'b0;
    #1 check_all_zero("async_reset");
    hpos = 10'd500;
    @(posedge clk); #1;
    check_all_zero("in_reset");
    #2 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hpos = (i % 2 == 0) ? 10'd500 : 10'd300;
      @(posedge clk); #1;
      check_all_zero("after_release");
    end
    full_line(32, 1);

    // Random lines, some restarted at a random point of the computation
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0: s = int'($urandom_range(0, 2047));
        1: s = int'($urandom_range(0, 64));
        2: s = int'($urandom_range(300, 340));
        default: s = int'($urandom_range(320, 700));
      endcase
      side = int'($urandom_range(0, 1));
      if (n % 2 == 1) begin
        capture_line(int'($urandom_range(0, 2047)), 1 - side);
        dly = int'($urandom_range(0, 30));
        repeat (dly) @(posedge clk);
        #1;
      end
      full_line(s, side);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
